// File: rtl/pipe_adder_tree_pkg.sv
// ============================================================================
// Module : pipe_adder_tree_pkg
// Brief  : Elaboration helpers shared by the pipelined adder tree.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_adder_tree_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int tree_levels(input int n_operands);
        return (n_operands > 1) ? $clog2(n_operands) : 0;
    endfunction

    // The last level is always registered so the output is a flop.
    function automatic bit stage_registered(input int lvl, input int levels, input int pipe_every);
        return (((lvl + 1) % pipe_every) == 0) || (lvl == levels - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_adder_tree_level.sv
// ============================================================================
// Module : adder_tree_level
// Brief  : One combinational tree level: adds adjacent operand pairs, width +1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_tree_level
    import pipe_adder_tree_pkg::*;
#(
    parameter int IN_WIDTH = 12,
    parameter int N_IN     = 5,
    parameter int SIGNED   = 1,
    localparam int N_OUT   = ceil_div(N_IN, 2)
) (
    input  logic [N_IN*IN_WIDTH-1:0]      in_ops,
    output logic [N_OUT*(IN_WIDTH+1)-1:0] out_sums
);

    localparam bit EXT_SIGN = (SIGNED != 0);

    for (genvar k = 0; k < N_OUT; k++) begin : g_pair
        logic [IN_WIDTH-1:0] op_a;
        logic [IN_WIDTH:0]   ext_a;

        assign op_a  = in_ops[2*k*IN_WIDTH +: IN_WIDTH];
        assign ext_a = {EXT_SIGN & op_a[IN_WIDTH-1], op_a};

        if (2*k + 1 < N_IN) begin : g_add
            logic [IN_WIDTH-1:0] op_b;
            logic [IN_WIDTH:0]   ext_b;

            assign op_b = in_ops[(2*k+1)*IN_WIDTH +: IN_WIDTH];
            assign ext_b = {EXT_SIGN & op_b[IN_WIDTH-1], op_b};
            assign out_sums[k*(IN_WIDTH+1) +: IN_WIDTH+1] = ext_a + ext_b;
        end else begin : g_pass
            // Odd leftover operand: widened only, summed at a later level.
            assign out_sums[k*(IN_WIDTH+1) +: IN_WIDTH+1] = ext_a;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_adder_tree.sv
// ============================================================================
// Module : pipe_adder_tree
// Brief  : Pipelined exact sum of LENGTH packed operands with valid/ready flow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_adder_tree
    import pipe_adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int LENGTH     = 5,
    parameter int SIGNED     = 1,
    parameter int PIPE_EVERY = 1,
    localparam int OUT_WIDTH = DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*LENGTH-1:0] in_addends,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_sum
);

    localparam int LEVELS = tree_levels(LENGTH);

    logic stall;
    logic advance;

    // A held output freezes the whole pipe; otherwise every stage moves, bubbles included.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    if (LEVELS == 0) begin : g_single
        logic [OUT_WIDTH-1:0] sum_d;
        logic [OUT_WIDTH-1:0] sum_q;
        logic                 valid_d;
        logic                 valid_q;

        always_comb begin
            sum_d   = sum_q;
            valid_d = valid_q;
            if (advance) begin
                sum_d   = in_addends;
                valid_d = in_valid;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                sum_q   <= sum_d;
                valid_q <= valid_d;
            end
        end

        assign out_sum   = sum_q;
        assign out_valid = valid_q;
    end else begin : g_tree
        for (genvar i = 0; i < LEVELS; i++) begin : g_level
            localparam int N_IN  = ceil_div(LENGTH, 1 << i);
            localparam int W_IN  = DATA_WIDTH + i;
            localparam int N_OUT = ceil_div(N_IN, 2);
            localparam int W_BUS = N_OUT * (W_IN + 1);

            logic [N_IN*W_IN-1:0] lvl_in;
            logic                 lvl_valid;
            logic [W_BUS-1:0]     lvl_sum;
            logic [W_BUS-1:0]     stage_data;
            logic                 stage_valid;

            if (i == 0) begin : g_first
                assign lvl_in    = in_addends;
                assign lvl_valid = in_valid;
            end else begin : g_next
                assign lvl_in    = g_level[i-1].stage_data;
                assign lvl_valid = g_level[i-1].stage_valid;
            end

            adder_tree_level #(
                .IN_WIDTH (W_IN),
                .N_IN     (N_IN),
                .SIGNED   (SIGNED)
            ) u_level (
                .in_ops   (lvl_in),
                .out_sums (lvl_sum)
            );

            if (stage_registered(i, LEVELS, PIPE_EVERY)) begin : g_reg
                logic [W_BUS-1:0] stage_data_d;
                logic [W_BUS-1:0] stage_data_q;
                logic             stage_valid_d;
                logic             stage_valid_q;

                always_comb begin
                    stage_data_d  = stage_data_q;
                    stage_valid_d = stage_valid_q;
                    if (advance) begin
                        stage_data_d  = lvl_sum;
                        stage_valid_d = lvl_valid;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_data_q  <= '0;
                        stage_valid_q <= 1'b0;
                    end else begin
                        stage_data_q  <= stage_data_d;
                        stage_valid_q <= stage_valid_d;
                    end
                end

                assign stage_data  = stage_data_q;
                assign stage_valid = stage_valid_q;
            end else begin : g_comb
                assign stage_data  = lvl_sum;
                assign stage_valid = lvl_valid;
            end
        end

        assign out_sum   = g_level[LEVELS-1].stage_data;
        assign out_valid = g_level[LEVELS-1].stage_valid;
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder_tree.sv
// ============================================================================
// Module : tb_pipe_adder_tree
// Brief  : Directed and random checks of pipe_adder_tree in four configurations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_adder_tree;

    logic clk;
    logic rst_n;

    // Signed, LENGTH=5, PIPE_EVERY=1
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [59:0] a_in;
    logic [14:0] a_out_sum;
    // Unsigned, LENGTH=5
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
    logic [59:0] u_in;
    logic [14:0] u_out_sum;
    // LENGTH=1
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [11:0] s_in;
    logic [11:0] s_out_sum;
    // LENGTH=8, PIPE_EVERY=2
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [95:0] h_in;
    logic [14:0] h_out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_adder_tree #(.DATA_WIDTH(12), .LENGTH(5), .SIGNED(1), .PIPE_EVERY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addends(a_in), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum));

    pipe_adder_tree #(.DATA_WIDTH(12), .LENGTH(5), .SIGNED(0), .PIPE_EVERY(1)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .in_addends(u_in), .out_valid(u_out_valid), .out_ready(u_out_ready), .out_sum(u_out_sum));

    pipe_adder_tree #(.DATA_WIDTH(12), .LENGTH(1), .SIGNED(1), .PIPE_EVERY(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_addends(s_in), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum));

    pipe_adder_tree #(.DATA_WIDTH(12), .LENGTH(8), .SIGNED(1), .PIPE_EVERY(2)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_addends(h_in), .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sum(h_out_sum));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed operand sets and their hand-computed signed sums.
    int ops [8][5] = '{
        '{1, 2, 3, 4, 5},
        '{-1, -1, -1, -1, -1},
        '{2047, 2047, 2047, 2047, 2047},
        '{100, -100, 200, -200, 50},
        '{0, 0, 0, 0, 0},
        '{2047, -2048, 2047, -2048, 1},
        '{10, 20, 30, 40, 50},
        '{-2048, -2048, 0, 0, 2047}
    };
    int exp_sum [8] = '{15, -5, 10235, 50, 0, -1, 150, -2049};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] pack5(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
        logic [59:0] r;
        r = {a4[11:0], a3[11:0], a2[11:0], a1[11:0], a0[11:0]};
        return r;
    endfunction

    // Stream ops[] through the signed DUT with an optional out_ready=0 window.
    task automatic run_stream(input int n, input int st, input int sl);
        int          sent = 0, rcv = 0, first = -1, last = -1, rdy_low = 0, te;
        bit          stalled, acc, xfer;
        logic [14:0] held = '0;
        logic [14:0] obs, e;
        for (int cyc = 0; cyc < 200 && rcv < n; cyc++) begin
            stalled     = (cyc >= st) && (cyc < st + sl);
            a_out_ready = !stalled;
            if (sent < n) begin
                a_in = pack5(ops[sent%8][0], ops[sent%8][1], ops[sent%8][2],
                             ops[sent%8][3], ops[sent%8][4]);
                a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check_eq("bp_out_valid", a_out_valid, 1);
                check_eq("bp_in_ready", a_in_ready, 0);
                if (cyc == st) held = a_out_sum;
                else           check_eq("bp_hold_sum", a_out_sum, held);
            end else if (!a_in_ready) begin
                rdy_low++;
            end
            acc  = a_in_valid & a_in_ready;
            xfer = a_out_valid & a_out_ready;
            obs  = a_out_sum;
            @(posedge clk); #1;
            if (acc) sent++;
            if (xfer) begin
                te = exp_sum[rcv%8];
                e  = te[14:0];
                check_eq($sformatf("stream_sum[%0d]", rcv), obs, e);
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        check_eq("stream_count", rcv, n);
        check_eq("stream_in_ready_high", rdy_low, 0);
        if (sl == 0) check_eq("stream_consecutive", last - first + 1, n);
    endtask

    // Random valid/ready traffic on the LENGTH=8 DUT against a queue model.
    task automatic run_rand_h(input int n);
        logic [14:0]       q[$];
        logic [95:0]       data = '0;
        logic [14:0]       obs, prev_sum = '0, e;
        logic signed [11:0] t;
        bit                pending = 0, acc, xfer, prev_stall = 0;
        int                sent = 0, rcv = 0, hold_bad = 0, spurious = 0, s;
        for (int cyc = 0; cyc < 60000 && rcv < n; cyc++) begin
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 8; k++) data[k*12 +: 12] = 12'($urandom);
                pending = 1;
            end
            h_in        = data;
            h_in_valid  = pending;
            h_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall && (!h_out_valid || h_out_sum !== prev_sum)) hold_bad++;
            acc        = h_in_valid & h_in_ready;
            xfer       = h_out_valid & h_out_ready;
            obs        = h_out_sum;
            prev_stall = h_out_valid & ~h_out_ready;
            prev_sum   = h_out_sum;
            @(posedge clk); #1;
            if (acc) begin
                s = 0;
                for (int k = 0; k < 8; k++) begin
                    t = data[k*12 +: 12];
                    s += t;
                end
                q.push_back(s[14:0]);
                pending = 0;
                sent++;
            end
            if (xfer) begin
                if (q.size() == 0) begin
                    spurious++;
                end else begin
                    e = q.pop_front();
                    check_eq($sformatf("rand_sum[%0d]", rcv), obs, e);
                end
                rcv++;
            end
        end
        h_in_valid  = 1'b0;
        h_out_ready = 1'b1;
        check_eq("rand_count", rcv, n);
        check_eq("rand_spurious", spurious, 0);
        check_eq("rand_stall_hold", hold_bad, 0);
    endtask

    int lat;
    int seen;

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_out_ready = 1; a_in = '0;
        u_in_valid = 0; u_out_ready = 1; u_in = '0;
        s_in_valid = 0; s_out_ready = 1; s_in = '0;
        h_in_valid = 0; h_out_ready = 1; h_in = '0;

        #12;
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_out_sum", a_out_sum, 0);
        check_eq("rst_in_ready", a_in_ready, 1);
        check_eq("rst_h_out_valid", h_out_valid, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed extremes, latency 3
        a_in = pack5(-2048, -2048, -2048, -2048, -2048);
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t1_latency", lat, 3);
        check_eq("t1_sum", a_out_sum, 15'h5800);
        @(posedge clk); #1;
        check_eq("t1_single_pulse", a_out_valid, 0);

        // Unsigned mode
        u_in = {5{12'hFFF}};
        u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        lat = 1;
        while (!u_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t2_latency", lat, 3);
        check_eq("t2_sum_fff", u_out_sum, 15'd20475);
        u_in = {12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
        u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        lat = 1;
        while (!u_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t2_sum_small", u_out_sum, 15'd15);
        @(posedge clk); #1;

        // Back-to-back, then backpressure
        run_stream(8, 0, 0);
        run_stream(8, 4, 4);

        // Reset with two sums in flight
        a_out_ready = 1'b1;
        a_in = pack5(1, 2, 3, 4, 5);
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in = pack5(10, 20, 30, 40, 50);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_pre_valid", a_out_valid, 1);
        check_eq("t5_pre_sum", a_out_sum, 15'd15);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", a_out_valid, 0);
        check_eq("t5_rst_sum", a_out_sum, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        check_eq("t5_no_stale", seen, 0);

        // LENGTH=1: latency 1, value passes through
        s_in = 12'h9AB;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t6_l1_latency", lat, 1);
        check_eq("t6_l1_sum", s_out_sum, 12'h9AB);
        @(posedge clk); #1;

        // LENGTH=8, PIPE_EVERY=2: latency 2
        h_in = {8{12'h7FF}};
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t6_l8_latency", lat, 2);
        check_eq("t6_l8_sum_max", h_out_sum, 15'h3FF8);
        h_in = {8{12'h800}};
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check_eq("t6_l8_sum_min", h_out_sum, 15'h4000);
        @(posedge clk); #1;

        run_rand_h(10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
